// File: rtl/mdl_mskreg.sv
// Mask shift register: serially captures bootloop mask bits into a store during
// acquisition and replays the store, one bit per slot event, after each load strobe.
module mdl_mskreg #(
    parameter int MASK_LEN = 16
) (
    input  logic                i_MCLK,
    input  logic                i_RST_n,
    input  logic                i_CLK2M_PCEN_n,
    input  logic [19:0]         i_ROT20_n,
    input  logic                i_4BEN_n,
    input  logic                i_ACQ_MSK,
    input  logic                i_BDI,
    input  logic                i_MSKREG_SR_LD,
    output logic                o_MSK_BIT,
    output logic                o_MSK_VALID,
    output logic                o_ACQ_DONE,
    output logic [MASK_LEN-1:0] o_MSK_STORE
);

    localparam int ACQ_W = (MASK_LEN > 1) ? $clog2(MASK_LEN) : 1;
    localparam int OUT_W = $clog2(MASK_LEN + 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(MASK_LEN - 1);
    localparam logic [OUT_W-1:0] OUT_FULL = OUT_W'(MASK_LEN);

    logic                tick;
    logic                slot_evt;
    logic                rot_unused;

    logic [MASK_LEN-1:0] store_q,    store_d;
    logic [MASK_LEN-1:0] out_sr_q,   out_sr_d;
    logic [ACQ_W-1:0]    acq_cnt_q,  acq_cnt_d;
    logic [OUT_W-1:0]    out_cnt_q,  out_cnt_d;
    logic                valid_q,    valid_d;
    logic                acq_done_q, acq_done_d;

    assign tick       = ~i_CLK2M_PCEN_n;
    // Phase 10 only counts as a slot in 4-bit mode, giving two slots per rotation.
    assign slot_evt   = ~i_ROT20_n[0] | (~i_4BEN_n & ~i_ROT20_n[10]);
    assign rot_unused = &{i_ROT20_n[19:11], i_ROT20_n[9:1]};

    always_comb begin
        store_d    = store_q;
        out_sr_d   = out_sr_q;
        acq_cnt_d  = acq_cnt_q;
        out_cnt_d  = out_cnt_q;
        valid_d    = valid_q;
        acq_done_d = acq_done_q;

        if (tick) begin
            acq_done_d = 1'b0;
            if (i_ACQ_MSK) begin
                if (slot_evt) begin
                    store_d = {store_q[MASK_LEN-2:0], i_BDI};
                    if (acq_cnt_q == ACQ_LAST) begin
                        acq_cnt_d  = '0;
                        acq_done_d = 1'b1;
                    end else begin
                        acq_cnt_d = acq_cnt_q + ACQ_W'(1);
                    end
                end
            end else begin
                acq_cnt_d = '0;
            end

            // Load reads the pre-shift store, so a same-tick capture lands next time.
            if (i_MSKREG_SR_LD) begin
                out_sr_d  = store_q;
                out_cnt_d = OUT_FULL;
                valid_d   = 1'b1;
            end else if (slot_evt && (out_cnt_q != '0)) begin
                out_sr_d  = {out_sr_q[MASK_LEN-2:0], 1'b0};
                out_cnt_d = out_cnt_q - OUT_W'(1);
                valid_d   = (out_cnt_q != OUT_W'(1));
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            store_q    <= '0;
            out_sr_q   <= '0;
            acq_cnt_q  <= '0;
            out_cnt_q  <= '0;
            valid_q    <= 1'b0;
            acq_done_q <= 1'b0;
        end else begin
            store_q    <= store_d;
            out_sr_q   <= out_sr_d;
            acq_cnt_q  <= acq_cnt_d;
            out_cnt_q  <= out_cnt_d;
            valid_q    <= valid_d;
            acq_done_q <= acq_done_d;
        end
    end

    assign o_MSK_BIT   = out_sr_q[MASK_LEN-1] & valid_q;
    assign o_MSK_VALID = valid_q;
    assign o_ACQ_DONE  = acq_done_q;
    assign o_MSK_STORE = store_q;

endmodule

// File: tb/tb_mdl_mskreg.sv
// Directed bench for mdl_mskreg: a reference model of the store plus a queue of
// pending mask bits (filled on load, drained on slot events) checks every step.
module tb_mdl_mskreg;

    logic        i_MCLK = 1'b0;
    logic        i_RST_n = 1'b1;
    logic        i_CLK2M_PCEN_n = 1'b1;
    logic [19:0] i_ROT20_n = '1;
    logic        i_4BEN_n = 1'b1;
    logic        i_ACQ_MSK = 1'b0;
    logic        i_BDI = 1'b0;
    logic        i_MSKREG_SR_LD = 1'b0;
    logic        o_MSK_BIT;
    logic        o_MSK_VALID;
    logic        o_ACQ_DONE;
    logic [15:0] o_MSK_STORE;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_store = '0;
    int          m_acq_cnt = 0;
    logic        m_done = 1'b0;
    bit          sb[$];
    logic [15:0] dut_seq = '0;

    mdl_mskreg #(.MASK_LEN(16)) dut (
        .i_MCLK         (i_MCLK),
        .i_RST_n        (i_RST_n),
        .i_CLK2M_PCEN_n (i_CLK2M_PCEN_n),
        .i_ROT20_n      (i_ROT20_n),
        .i_4BEN_n       (i_4BEN_n),
        .i_ACQ_MSK      (i_ACQ_MSK),
        .i_BDI          (i_BDI),
        .i_MSKREG_SR_LD (i_MSKREG_SR_LD),
        .o_MSK_BIT      (o_MSK_BIT),
        .o_MSK_VALID    (o_MSK_VALID),
        .o_ACQ_DONE     (o_ACQ_DONE),
        .o_MSK_STORE    (o_MSK_STORE)
    );

    always #5 i_MCLK = ~i_MCLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStep(input string tag);
        checkOutput({tag, "_valid"}, 64'(o_MSK_VALID), 64'(sb.size() != 0));
        checkOutput({tag, "_bit"}, 64'(o_MSK_BIT), 64'((sb.size() != 0) ? sb[0] : 1'b0));
        checkOutput({tag, "_done"}, 64'(o_ACQ_DONE), 64'(m_done));
        checkOutput({tag, "_store"}, 64'(o_MSK_STORE), 64'(m_store));
    endtask

    // One MCLK: drive at negedge, model the posedge, compare at the next negedge.
    task automatic applyStimulus(input string tag, input bit tk, input int phase,
                                 input bit ben4_n, input bit acq, input bit bdi, input bit ld);
        logic [19:0] rot;
        bit          se;
        logic        pre_bit;
        rot = '1;
        if (phase >= 0) rot[phase] = 1'b0;
        se = (phase == 0) || (!ben4_n && phase == 10);
        pre_bit = o_MSK_BIT;
        i_CLK2M_PCEN_n = !tk;
        i_ROT20_n      = rot;
        i_4BEN_n       = ben4_n;
        i_ACQ_MSK      = acq;
        i_BDI          = bdi;
        i_MSKREG_SR_LD = ld;
        @(posedge i_MCLK);
        if (tk) begin
            m_done = acq && se && (m_acq_cnt == 15);
            if (ld) begin
                sb.delete();
                for (int i = 15; i >= 0; i--) sb.push_back(m_store[i]);
            end else if (se && sb.size() != 0) begin
                void'(sb.pop_front());
                dut_seq = {dut_seq[14:0], pre_bit};
            end
            if (acq && se) begin
                m_store   = {m_store[14:0], bdi};
                m_acq_cnt = (m_acq_cnt == 15) ? 0 : m_acq_cnt + 1;
            end else if (!acq) begin
                m_acq_cnt = 0;
            end
        end
        @(negedge i_MCLK);
        i_CLK2M_PCEN_n = 1'b1;
        i_ROT20_n      = '1;
        i_MSKREG_SR_LD = 1'b0;
        checkStep(tag);
    endtask

    task automatic doReset();
        i_RST_n        = 1'b0;
        i_CLK2M_PCEN_n = 1'b1;
        i_ROT20_n      = '1;
        @(posedge i_MCLK);
        sb.delete();
        m_store   = '0;
        m_acq_cnt = 0;
        m_done    = 1'b0;
        @(negedge i_MCLK);
        i_RST_n = 1'b1;
        checkStep("reset");
    endtask

    initial begin
        logic [15:0] pat;
        int          ph;

        doReset();

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       ph = 0;
                1:       ph = 10;
                default: ph = 5;
            endcase
            applyStimulus("rand", 1'($urandom), ph, 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom_range(0, 4) == 0));
        end
        doReset();
        checkOutput("rst_valid", 64'(o_MSK_VALID), 64'd0);
        checkOutput("rst_store", 64'(o_MSK_STORE), 64'd0);

        $display("[TB] acquisition, 2-bit mode");
        pat = 16'hA5C3;
        for (int i = 15; i >= 0; i--) applyStimulus("acq", 1, 0, 1, 1, pat[i], 0);
        checkOutput("acq_store", 64'(o_MSK_STORE), 64'h0000_0000_0000_A5C3);
        checkOutput("acq_done_hi", 64'(o_ACQ_DONE), 64'd1);
        applyStimulus("acq_idle", 1, 5, 1, 1, 0, 0);
        checkOutput("acq_done_lo", 64'(o_ACQ_DONE), 64'd0);
        applyStimulus("acq17", 1, 0, 1, 1, 1, 0);
        checkOutput("acq17_store", 64'(o_MSK_STORE), 64'h0000_0000_0000_4B87);
        for (int i = 15; i >= 0; i--) applyStimulus("reacq", 1, 0, 1, 1, pat[i], 0);

        $display("[TB] load and shift, 2-bit mode");
        applyStimulus("ld2", 1, 5, 1, 0, 0, 1);
        checkOutput("ld2_valid", 64'(o_MSK_VALID), 64'd1);
        dut_seq = '0;
        for (int i = 0; i < 16; i++) applyStimulus("sh2", 1, 0, 1, 0, 0, 0);
        checkOutput("sh2_seq", 64'(dut_seq), 64'h0000_0000_0000_A5C3);
        checkOutput("sh2_end_valid", 64'(o_MSK_VALID), 64'd0);
        applyStimulus("underrun", 1, 0, 1, 0, 0, 0);
        checkOutput("underrun_bit", 64'(o_MSK_BIT), 64'd0);

        $display("[TB] load and shift, 4-bit mode");
        applyStimulus("ld4", 1, 5, 0, 0, 0, 1);
        dut_seq = '0;
        for (int r = 0; r < 8; r++) begin
            applyStimulus("sh4_p0", 1, 0, 0, 0, 0, 0);
            applyStimulus("sh4_p5", 1, 5, 0, 0, 0, 0);
            applyStimulus("sh4_p10", 1, 10, 0, 0, 0, 0);
        end
        checkOutput("sh4_seq", 64'(dut_seq), 64'h0000_0000_0000_A5C3);
        checkOutput("sh4_end_valid", 64'(o_MSK_VALID), 64'd0);

        $display("[TB] reload mid-stream");
        for (int i = 0; i < 11; i++) applyStimulus("fill1", 1, 0, 1, 1, 1, 0);
        checkOutput("fill1_store", 64'(o_MSK_STORE), 64'h0000_0000_0000_1FFF);
        applyStimulus("ldA", 1, 5, 1, 0, 0, 1);
        dut_seq = '0;
        for (int i = 0; i < 5; i++) applyStimulus("mid", 1, 0, 1, 1, 1, 0);
        checkOutput("mid_bits", 64'(dut_seq[4:0]), 64'h3);
        checkOutput("mid_store", 64'(o_MSK_STORE), 64'h0000_0000_0000_FFFF);
        applyStimulus("reload", 1, 5, 1, 0, 0, 1);
        checkOutput("reload_valid", 64'(o_MSK_VALID), 64'd1);
        dut_seq = '0;
        for (int i = 0; i < 16; i++) applyStimulus("sh_ones", 1, 0, 1, 0, 0, 0);
        checkOutput("ones_seq", 64'(dut_seq), 64'h0000_0000_0000_FFFF);

        $display("[TB] simultaneous load and capture");
        pat = 16'h8001;
        for (int i = 15; i >= 0; i--) applyStimulus("acq8001", 1, 0, 1, 1, pat[i], 0);
        applyStimulus("ldcap", 1, 0, 1, 1, 1, 1);
        checkOutput("ldcap_store", 64'(o_MSK_STORE), 64'h0000_0000_0000_0003);
        checkOutput("ldcap_bit", 64'(o_MSK_BIT), 64'd1);
        applyStimulus("ldcap_sh", 1, 0, 1, 0, 0, 0);
        applyStimulus("ldcap_sh", 1, 0, 1, 0, 0, 0);
        doReset();
        checkOutput("midrst_valid", 64'(o_MSK_VALID), 64'd0);
        applyStimulus("post_rst_se", 1, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
